// File: rtl/timer_counter0.sv
// 8051-style Timer/Counter 0: prescaled machine-cycle tick, modes 0-3, TF0 flag and mode-3 TF1 set pulse.
// Latency: count registers, tf0 and tf1_set all update on the same clk edge as the counting event.
// Backpressure: none; software writes take priority over counting and suppress overflow from the written half.
module timer_counter0 #(
  parameter int DIV = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] tmod,
  input  logic       tr0,
  input  logic       tr1,
  input  logic       int0_n,
  input  logic       t0_pin,
  input  logic [7:0] din,
  input  logic       wr_tl,
  input  logic       wr_th,
  input  logic       tf0_clr,
  output logic [7:0] tl,
  output logic [7:0] th,
  output logic       tf0,
  output logic       tf1_set
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] pre;
  logic          mc_tick;
  logic          gate;
  logic          c_t;
  logic [1:0]    mode;
  logic          run;
  logic          t0_q;
  logic          inc;
  logic [12:0]   c13;
  logic [15:0]   c16;
  logic [7:0]    tl_nxt;
  logic [7:0]    th_nxt;
  logic          ovf0;
  logic          ovf1;

  assign gate    = tmod[3];
  assign c_t     = tmod[2];
  assign mode    = tmod[1:0];
  assign mc_tick = (pre == PW'(DIV - 1));
  assign run     = tr0 & (~gate | int0_n);
  // Counter mode counts a 1->0 transition seen across two machine-cycle samples of t0_pin.
  assign inc     = run & mc_tick & (~c_t | (t0_q & ~t0_pin));
  assign c13     = {th, tl[4:0]} + 13'd1;
  assign c16     = {th, tl} + 16'd1;

  // Free-running prescaler 0..DIV-1; mc_tick marks the last clk of each machine cycle.
  always_ff @(posedge clk) begin
    if (reset || mc_tick) pre <= '0;
    else                  pre <= pre + PW'(1);
  end

  // Next count and overflow per mode; writes override the count of the half they target.
  always_comb begin
    tl_nxt = tl;
    th_nxt = th;
    ovf0   = 1'b0;
    ovf1   = 1'b0;
    case (mode)
      2'b00: if (inc) begin
        tl_nxt = {tl[7:5], c13[4:0]};
        th_nxt = c13[12:5];
        ovf0   = (c13 == 13'd0);
      end
      2'b01: if (inc) begin
        {th_nxt, tl_nxt} = c16;
        ovf0             = (c16 == 16'd0);
      end
      2'b10: if (inc) begin
        if (tl == 8'hFF) begin
          tl_nxt = th;
          ovf0   = 1'b1;
        end else begin
          tl_nxt = tl + 8'd1;
        end
      end
      default: begin
        if (inc) begin
          tl_nxt = tl + 8'd1;
          ovf0   = (tl == 8'hFF);
        end
        // TH half in mode 3 is a plain timer gated only by TR1.
        if (mc_tick && tr1) begin
          th_nxt = th + 8'd1;
          ovf1   = (th == 8'hFF);
        end
      end
    endcase
    if (wr_tl) begin
      tl_nxt = din;
      ovf0   = 1'b0;
      // In the cascaded modes a written TL produces no carry into TH.
      if (!mode[1]) th_nxt = th;
    end
    if (wr_th) begin
      th_nxt = din;
      if (!mode[1])      ovf0 = 1'b0;
      if (mode == 2'b11) ovf1 = 1'b0;
    end
  end

  // Count registers, flags and the machine-cycle sample of t0_pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      tl      <= 8'h00;
      th      <= 8'h00;
      tf0     <= 1'b0;
      tf1_set <= 1'b0;
      t0_q    <= 1'b0;
    end else begin
      tl      <= tl_nxt;
      th      <= th_nxt;
      tf1_set <= ovf1;
      if (ovf0)         tf0 <= 1'b1;
      else if (tf0_clr) tf0 <= 1'b0;
      if (mc_tick) t0_q <= t0_pin;
    end
  end

endmodule

// File: tb/tb_timer_counter0.sv
// Bench for timer_counter0: directed scenarios then randomized traffic against a behavioural model.
// The model tracks whole count values with integer arithmetic and counts clks since reset for the tick.
// Every clk compares tl, th, tf0 and tf1_set; directed steps add fixed expected values.
module tb_timer_counter0;
  localparam int DIV = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] tmod = 4'h0;
  logic       tr0 = 1'b0, tr1 = 1'b0, int0_n = 1'b1, t0_pin = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_tl = 1'b0, wr_th = 1'b0, tf0_clr = 1'b0;
  logic [7:0] tl, th;
  logic       tf0, tf1_set;

  timer_counter0 #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .tmod(tmod), .tr0(tr0), .tr1(tr1), .int0_n(int0_n),
    .t0_pin(t0_pin), .din(din), .wr_tl(wr_tl), .wr_th(wr_th), .tf0_clr(tf0_clr),
    .tl(tl), .th(th), .tf0(tf0), .tf1_set(tf1_set)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int m_tl = 0, m_th = 0, m_tf0 = 0, m_tf1 = 0, m_t0q = 0, m_n = 0;
  bit last_tick = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: advances one clk from the inputs present before the edge.
  task automatic model_edge();
    bit tick, run, inc, ovf, ovf1;
    int cnt, ntl, nth;
    if (reset) begin
      m_tl = 0; m_th = 0; m_tf0 = 0; m_tf1 = 0; m_t0q = 0; m_n = 0; last_tick = 0;
      return;
    end
    tick = ((m_n % DIV) == DIV - 1);
    run  = tr0 && (!tmod[3] || int0_n);
    inc  = run && tick && (!tmod[2] || (m_t0q == 1 && !t0_pin));
    ntl = m_tl; nth = m_th; ovf = 0; ovf1 = 0;
    case (int'(tmod[1:0]))
      0: if (inc) begin
        cnt = (m_th * 32 + m_tl % 32 + 1) % 8192;
        ovf = (cnt == 0);
        ntl = (m_tl / 32) * 32 + cnt % 32;
        nth = cnt / 32;
      end
      1: if (inc) begin
        cnt = (m_th * 256 + m_tl + 1) % 65536;
        ovf = (cnt == 0);
        ntl = cnt % 256;
        nth = cnt / 256;
      end
      2: if (inc) begin
        if (m_tl == 255) begin ovf = 1; ntl = m_th; end
        else ntl = m_tl + 1;
      end
      default: begin
        if (inc) begin ntl = (m_tl + 1) % 256; ovf = (m_tl == 255); end
        if (tick && tr1) begin nth = (m_th + 1) % 256; ovf1 = (m_th == 255); end
      end
    endcase
    if (wr_tl) begin
      ntl = int'(din); ovf = 0;
      if (tmod[1:0] < 2'd2) nth = m_th;
    end
    if (wr_th) begin
      nth = int'(din);
      if (tmod[1:0] < 2'd2) ovf = 0;
      if (tmod[1:0] == 2'd3) ovf1 = 0;
    end
    if (ovf) m_tf0 = 1;
    else if (tf0_clr) m_tf0 = 0;
    m_tf1 = ovf1;
    m_tl = ntl;
    m_th = nth;
    if (tick) m_t0q = t0_pin;
    m_n++;
    last_tick = tick;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("tl", 16'(tl), 16'(m_tl));
    chk("th", 16'(th), 16'(m_th));
    chk("tf0", 16'(tf0), 16'(m_tf0));
    chk("tf1_set", 16'(tf1_set), 16'(m_tf1));
    wr_tl = 0; wr_th = 0; tf0_clr = 0;
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin cyc(); k++; end while (!last_tick && k < 2 * DIV);
  endtask

  task automatic wait_pre_tick();
    int k = 0;
    while (((m_n % DIV) != DIV - 1) && k < 2 * DIV) begin cyc(); k++; end
  endtask

  task automatic write_both(input logic [7:0] vh, input logic [7:0] vl);
    din = vl; wr_tl = 1; cyc();
    din = vh; wr_th = 1; cyc();
  endtask

  initial begin
    // Reset state
    reset = 1; cyc(); cyc();
    reset = 0;
    chk("rst_tl", 16'(tl), 16'h0);
    chk("rst_th", 16'(th), 16'h0);
    chk("rst_tf0", 16'(tf0), 16'h0);
    // First tick lands DIV clks after reset release
    for (int i = 0; i < DIV - 1; i++) cyc();
    chk("first_tick_not_yet", 16'(last_tick), 16'h0);
    cyc();
    chk("first_tick", 16'(last_tick), 16'h1);

    // Mode 1 overflow FFFF->0000, then clear
    tmod = 4'b0001; tr0 = 0;
    write_both(8'hFF, 8'hFE);
    tr0 = 1;
    wait_tick();
    wait_tick();
    chk("m1_tl", 16'(tl), 16'h00);
    chk("m1_th", 16'(th), 16'h00);
    chk("m1_tf0", 16'(tf0), 16'h1);
    tr0 = 0; tf0_clr = 1; cyc();
    chk("m1_clr", 16'(tf0), 16'h0);

    // Mode 2 reload
    tmod = 4'b0010;
    write_both(8'hF0, 8'hFF);
    tr0 = 1;
    wait_tick();
    chk("m2_tl", 16'(tl), 16'hF0);
    chk("m2_th", 16'(th), 16'hF0);
    chk("m2_tf0", 16'(tf0), 16'h1);

    // Mode 0 13-bit wrap with tl[7:5] held
    tr0 = 0; tmod = 4'b0000; tf0_clr = 1; cyc();
    write_both(8'hFF, 8'h3F);
    tr0 = 1;
    wait_tick();
    chk("m0_th", 16'(th), 16'h00);
    chk("m0_tl", 16'(tl), 16'h20);
    chk("m0_tf0", 16'(tf0), 16'h1);

    // Gated counter mode
    tr0 = 0; tmod = 4'b1101; tf0_clr = 1; cyc();
    write_both(8'h00, 8'h00);
    tr0 = 1; int0_n = 0;
    for (int i = 0; i < 6; i++) begin t0_pin = ~t0_pin; wait_tick(); end
    chk("gate_hold", 16'(tl), 16'h00);
    int0_n = 1; t0_pin = 1; wait_tick();
    t0_pin = 0; wait_tick();
    chk("ct_edge", 16'(tl), 16'h01);
    wait_tick();
    chk("ct_no_edge", 16'(tl), 16'h01);

    // Mode 3 TH timer overflow pulses tf1_set
    tr0 = 0; tr1 = 1; tmod = 4'b0011; tf0_clr = 1; cyc();
    write_both(8'hFF, 8'h12);
    wait_tick();
    chk("m3_th", 16'(th), 16'h00);
    chk("m3_tf1", 16'(tf1_set), 16'h1);
    chk("m3_tl", 16'(tl), 16'h12);
    chk("m3_tf0", 16'(tf0), 16'h0);
    cyc();
    chk("m3_tf1_pulse", 16'(tf1_set), 16'h0);

    // Overflow coincident with clear: set wins
    tr1 = 0; tmod = 4'b0001;
    write_both(8'hFF, 8'hFF);
    tr0 = 1;
    wait_pre_tick();
    tf0_clr = 1; cyc();
    chk("set_prio_tf0", 16'(tf0), 16'h1);
    chk("set_prio_tl", 16'(tl), 16'h00);

    // Write on an increment cycle beats the count
    tr0 = 0; tf0_clr = 1; cyc();
    write_both(8'hFF, 8'hFF);
    tr0 = 1;
    wait_pre_tick();
    din = 8'h55; wr_tl = 1; cyc();
    chk("wr_prio_tl", 16'(tl), 16'h55);
    chk("wr_prio_th", 16'(th), 16'hFF);
    chk("wr_prio_tf0", 16'(tf0), 16'h0);

    // Reset mid-count
    wait_tick();
    reset = 1; cyc(); reset = 0;
    chk("mid_rst_tl", 16'(tl), 16'h00);
    chk("mid_rst_th", 16'(th), 16'h00);
    chk("mid_rst_tf0", 16'(tf0), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) tmod = 4'($urandom);
      tr0     = ($urandom_range(0, 7) != 0);
      tr1     = 1'($urandom);
      int0_n  = 1'($urandom);
      t0_pin  = 1'($urandom);
      din     = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      wr_tl   = ($urandom_range(0, 15) == 0);
      wr_th   = ($urandom_range(0, 15) == 0);
      tf0_clr = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 400) == 0);
      cyc();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
